// File: rtl/tree_path_tracker_if.sv
// Operation, table-programming and result signals of tree_path_tracker.
// The master side is whoever drives operations and consumes results; the
// slave side is the tracker itself.
interface tree_path_tracker_if #(
  parameter int NUM_MSG_HIERARCHY = 4,
  parameter int NUM_MSGS          = 8,
  parameter int IDENTIFIER_SIZE   = 5,
  parameter int NODE_DATA_W       = 4
);
  localparam int IDX_W   = $clog2(NUM_MSGS);
  localparam int DEPTH_W = $clog2(NUM_MSG_HIERARCHY + 1);
  localparam int PATH_W  = NUM_MSG_HIERARCHY * IDENTIFIER_SIZE;

  // Operation stream
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_op;
  logic [IDENTIFIER_SIZE-1:0] in_id;

  // Dependency table programming
  logic                       cfg_we;
  logic [IDX_W-1:0]           cfg_idx;
  logic [PATH_W-1:0]          cfg_path;
  logic [DEPTH_W-1:0]         cfg_len;
  logic [NODE_DATA_W-1:0]     cfg_data;

  // Result stream and sticky error flags
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_match;
  logic [NODE_DATA_W-1:0]     out_node_data;
  logic [DEPTH_W-1:0]         out_depth;
  logic                       out_err;
  logic                       err_overflow;
  logic                       err_underflow;

  modport master (
    output in_valid, in_op, in_id,
    output cfg_we, cfg_idx, cfg_path, cfg_len, cfg_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_match, out_node_data, out_depth, out_err,
    input  err_overflow, err_underflow
  );

  modport slave (
    input  in_valid, in_op, in_id,
    input  cfg_we, cfg_idx, cfg_path, cfg_len, cfg_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_match, out_node_data, out_depth, out_err,
    output err_overflow, err_underflow
  );
endinterface

// File: rtl/tree_path_tracker.sv
// Tracks the identifier path of a decoder walking a message tree and looks
// the path up in a programmable dependency table after every operation.
// One registered result stage; an operation is taken whenever the result
// register is empty or being drained in the same cycle.
module tree_path_tracker #(
  parameter int NUM_MSG_HIERARCHY = 4,
  parameter int NUM_MSGS          = 8,
  parameter int IDENTIFIER_SIZE   = 5,
  parameter int NODE_DATA_W       = 4
) (
  input logic                clk,
  input logic                rst,
  tree_path_tracker_if.slave bus
);
  localparam int DEPTH_W = $clog2(NUM_MSG_HIERARCHY + 1);
  localparam int PATH_W  = NUM_MSG_HIERARCHY * IDENTIFIER_SIZE;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_POP   = 2'd1,
    OP_CLEAR = 2'd2,
    OP_QUERY = 2'd3
  } op_e;

  typedef logic [DEPTH_W-1:0]     depth_t;
  typedef logic [PATH_W-1:0]      path_t;
  typedef logic [NODE_DATA_W-1:0] data_t;

  localparam depth_t MAX_DEPTH = depth_t'(NUM_MSG_HIERARCHY);

  // Identifier stack, level 0 in the low slot
  path_t  r_stack;
  depth_t r_depth;

  // Dependency table; an entry with length 0 is invalid
  path_t  r_tbl_path [NUM_MSGS];
  depth_t r_tbl_len  [NUM_MSGS];
  data_t  r_tbl_data [NUM_MSGS];

  // Result register and sticky errors
  logic   r_out_valid;
  logic   r_out_match;
  data_t  r_out_data;
  logic   r_out_err;
  logic   r_err_ovf;
  logic   r_err_unf;

  logic   w_accept;
  logic   w_cfg_ok;
  op_e    w_op;
  logic   w_push_ok;
  logic   w_ovf;
  logic   w_unf;
  depth_t w_depth_nxt;
  path_t  w_path_nxt;
  path_t  w_mask;
  logic   w_match;
  data_t  w_data;

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_op         = op_e'(bus.in_op);
  assign w_cfg_ok     = bus.cfg_we && (32'(bus.cfg_idx) < NUM_MSGS);

  // Post-operation stack and depth, plus the slot mask covering that depth
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through the block leaves it unassigned and no latch is inferred.
    w_push_ok   = 1'b0;
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    w_depth_nxt = r_depth;
    case (w_op)
      OP_PUSH: begin
        if (r_depth == MAX_DEPTH) begin
          w_ovf = 1'b1;
        end else begin
          w_push_ok   = 1'b1;
          w_depth_nxt = r_depth + depth_t'(1);
        end
      end
      OP_POP: begin
        if (r_depth == '0) w_unf = 1'b1;
        else               w_depth_nxt = r_depth - depth_t'(1);
      end
      OP_CLEAR: w_depth_nxt = '0;
      default:  ;
    endcase

    w_path_nxt = r_stack;
    w_mask     = '0;
    for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
      if (w_push_ok && depth_t'(k) == r_depth)
        w_path_nxt[k*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] = bus.in_id;
      if (depth_t'(k) < w_depth_nxt)
        w_mask[k*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] = '1;
    end
  end

  // Table lookup on the post-operation path; scanning downwards lets the
  // lowest matching index overwrite any higher one
  always_comb begin
    w_match = 1'b0;
    w_data  = '0;
    for (int e = NUM_MSGS - 1; e >= 0; e--) begin
      if (r_tbl_len[e] != '0 && r_tbl_len[e] == w_depth_nxt &&
          ((r_tbl_path[e] ^ w_path_nxt) & w_mask) == '0) begin
        w_match = 1'b1;
        w_data  = r_tbl_data[e];
      end
    end
    if (w_ovf || w_unf) begin
      w_match = 1'b0;
      w_data  = '0;
    end
  end

  // Depth, result register and sticky error flags
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      r_depth     <= '0;
      r_out_valid <= 1'b0;
      r_out_match <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_unf   <= 1'b0;
    end else if (w_accept) begin
      r_depth     <= w_depth_nxt;
      r_out_valid <= 1'b1;
      r_out_match <= w_match;
      r_out_data  <= w_data;
      r_out_err   <= w_ovf || w_unf;
      if (w_ovf) r_err_ovf <= 1'b1;
      if (w_unf) r_err_unf <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Stack slots; contents above the depth are never looked at
  always_ff @(posedge clk) begin
    if (w_accept) r_stack <= w_path_nxt;
  end

  // Entry lengths carry the valid state and are the only table field reset
  always_ff @(posedge clk) begin
    // NOTE: only the length array is reset; path and data behind a zero
    // length are unused, so leaving them unreset keeps them plain storage.
    if (rst) begin
      for (int e = 0; e < NUM_MSGS; e++) r_tbl_len[e] <= '0;
    end else if (w_cfg_ok) begin
      r_tbl_len[bus.cfg_idx] <= bus.cfg_len;
    end
  end

  // Entry path and node data
  always_ff @(posedge clk) begin
    if (w_cfg_ok) begin
      r_tbl_path[bus.cfg_idx] <= bus.cfg_path;
      r_tbl_data[bus.cfg_idx] <= bus.cfg_data;
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.out_match     = r_out_match;
  assign bus.out_node_data = r_out_data;
  assign bus.out_depth     = r_depth;
  assign bus.out_err       = r_out_err;
  assign bus.err_overflow  = r_err_ovf;
  assign bus.err_underflow = r_err_unf;
endmodule

// File: doc/tree_path_tracker.md
Name: tree_path_tracker

Overview:
Parametrised, runtime-programmable successor to the fixed dependency/node-ROM tables. Consumes a stream of push/pop identifier operations as a decoder descends and ascends the message tree, and keeps the current identifier path on an internal stack. On every operation it matches the new path against a table of NUM_MSGS programmable dependency paths and returns the matching node_data. It sits between the field-tag decoder and the downstream per-message logic.

Parameters:
NUM_MSG_HIERARCHY, 4, maximum tree depth, which is both the stack depth and the table path length.
NUM_MSGS, 8, number of dependency table entries.
IDENTIFIER_SIZE, 5, identifier width in bits.
NODE_DATA_W, 4, width of the node_data payload (message/var type).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operation valid.
in_ready  out  1  operation accepted when in_valid && in_ready.
in_op  in  2  0=PUSH, 1=POP, 2=CLEAR, 3=QUERY (re-look-up the current path, no stack change).
in_id  in  IDENTIFIER_SIZE  identifier for PUSH; ignored for other ops.
cfg_we  in  1  table write strobe.
cfg_idx  in  $clog2(NUM_MSGS)  table entry index.
cfg_path  in  NUM_MSG_HIERARCHY*IDENTIFIER_SIZE  slot k = bits [k*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] = identifier at level k; level 0 is the outermost.
cfg_len  in  $clog2(NUM_MSG_HIERARCHY+1)  path length; 0 invalidates the entry.
cfg_data  in  NODE_DATA_W  node_data for the entry.
out_valid  out  1  result valid.
out_ready  in  1  result consumed when out_valid && out_ready.
out_match  out  1  the path matched a valid entry.
out_node_data  out  NODE_DATA_W  node_data of the matched entry; 0 when there is no match.
out_depth  out  $clog2(NUM_MSG_HIERARCHY+1)  stack depth after the operation.
out_err  out  1  this operation overflowed or underflowed.
err_overflow  out  1  sticky; set by a PUSH at full depth.
err_underflow  out  1  sticky; set by a POP at depth 0.

Behaviour:
- Reset: depth=0, all table entries invalid, out_valid=0, out_match=0, out_node_data=0, out_depth=0, out_err=0, both sticky errors=0. Reset mid-operation discards any pending result.
- Handshake: in_ready = !out_valid || out_ready. This is a single registered stage with full throughput: one operation per cycle while out_ready=1. When out_valid=1 and out_ready=0, all outputs hold stable.
- Latency: the result for an operation accepted in cycle N appears with out_valid=1 in cycle N+1.
- PUSH with depth<NUM_MSG_HIERARCHY: stack[depth]=in_id, depth+1.
- PUSH with depth==NUM_MSG_HIERARCHY: stack is unchanged; out_err=1, out_match=0, err_overflow set.
- POP with depth>0: depth-1; the popped slot's contents are don't-care.
- POP with depth==0: stack is unchanged; out_err=1, out_match=0, err_underflow set.
- CLEAR: depth=0, out_match=0. Sticky errors are not cleared; only rst clears them.
- QUERY: looks up the current path; no stack change.
- Lookup: uses the post-operation path. An entry matches when it is valid, cfg_len==depth, and slots 0..depth-1 are equal to stack[0..depth-1]. Slots at or above len are ignored.
  - Depth 0 never matches.
  - When several entries match, the lowest index wins.
- Table write: a cfg_we write updates the entry at the clock edge. A lookup in the same cycle uses the old contents; the new contents are visible from the next accepted operation. cfg_we is accepted regardless of the in/out handshake state.
- cfg_idx>=NUM_MSGS: the write is ignored.

Test Plan:
- Program entry0={01},len1,data0 and entry1={01,04},len2,data1. Then PUSH 01 -> match=1, data=0, depth=1. PUSH 04 -> match=1, data=1, depth=2. PUSH 07 -> match=0, data=0, depth=3. POP -> match=1, data=1, depth=2.
- With NUM_MSG_HIERARCHY=4, issue five PUSH 02 -> fifth result has out_err=1, depth=4, err_overflow=1. Then CLEAR and POP -> out_err=1, depth=0, err_underflow=1, err_overflow still 1.
- Back-to-back PUSH 01, PUSH 04, POP, QUERY with out_ready held 0 for 3 cycles after the first result -> in_ready=0 and outputs stable while stalled; results arrive in order as 0/1/0(match, depth1)/0.
- Program entry3 and entry5 both ={01,04},len2 with data 9 and 3 -> PUSH 01, PUSH 04 returns data=9. Write entry3 len=0 -> QUERY returns data=3.
- cfg_we entry1 data=6 in the same cycle as QUERY at path {01,04} -> that query returns 1; the next QUERY returns 6.
- Assert rst while depth=3 and out_valid=1 -> next cycle out_valid=0, depth=0, table invalid; PUSH 01 -> match=0.
